// File: rtl/sa_pkg.sv
// Shared types and default sizes for the systolic-array feeder.
package sa_pkg;

    localparam int DEF_BN_NUM   = 4;
    localparam int DEF_ACCU_NUM = 2;
    localparam int DEF_BW_ACT   = 8;
    localparam int DEF_BW_WET   = 8;

    // Loop counters are kept at one generous width so that compares stay width-matched
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        FEED,
        DRAIN,
        CLEAR,
        CAPTURE,
        WRITE,
        DONE
    } state_t;

    typedef logic signed [DEF_BW_ACT-1:0] act_t;
    typedef logic signed [DEF_BW_WET-1:0] wet_t;

endpackage

// File: rtl/sa_feed_skew.sv
// Skewed activation addressing: lane idx on feed step l carries row (l-1-idx) of the current tile.
module sa_feed_skew
    import sa_pkg::*;
#(
    parameter int BN_NUM   = DEF_BN_NUM,
    parameter int ACCU_NUM = DEF_ACCU_NUM,
    parameter int ROW_W    = 3,
    parameter int COL_W    = 3
) (
    input  logic [CNT_W-1:0]                  l,
    input  logic [CNT_W-1:0]                  i,
    input  logic [CNT_W-1:0]                  j,
    output logic [ACCU_NUM-1:0][ROW_W-1:0]    rows,
    output logic [ACCU_NUM-1:0][COL_W-1:0]    cols,
    output logic [ACCU_NUM-1:0]               valid
);

    int diff;

    // Per-lane address and validity; invalid lanes get address 0 and are masked downstream
    always_comb begin
        diff  = 0;
        rows  = '0;
        cols  = '0;
        valid = '0;
        for (int idx = 0; idx < ACCU_NUM; idx++) begin
            diff       = int'(l) - 1 - idx;
            valid[idx] = (diff >= 0) && (diff < BN_NUM);
            if (valid[idx]) begin
                rows[idx] = ROW_W'(int'(j) * BN_NUM + diff);
                cols[idx] = COL_W'(int'(i) * ACCU_NUM + idx);
            end
        end
    end

endmodule

// File: rtl/sa_feeder.sv
// Sequencer feeding one systolic PE column from activation/weight buffers and
// writing captured results to the output-activation buffer.
// Optional macro SA_FEEDER_PERF_EN adds perf_cycles / perf_writes counters.
module sa_feeder
    import sa_pkg::*;
#(
    parameter int BN_NUM    = DEF_BN_NUM,
    parameter int ACCU_NUM  = DEF_ACCU_NUM,
    parameter int BW_ACT    = DEF_BW_ACT,
    parameter int BW_WET    = DEF_BW_WET,
    parameter int IA_H      = 8,
    parameter int IA_W      = 8,
    parameter int OA_W      = 8,
    parameter int DRAIN_CYC = 3
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
    input  logic [7:0]                              res_shift_num,
    output logic [ACCU_NUM-1:0][$clog2(IA_H)-1:0]   act_rd_row,
    output logic [ACCU_NUM-1:0][$clog2(IA_W)-1:0]   act_rd_col,
    input  logic [ACCU_NUM-1:0][BW_ACT-1:0]         act_rd_data,
    output logic [$clog2(IA_W)-1:0]                 wet_rd_row,
    output logic [$clog2(OA_W)-1:0]                 wet_rd_col,
    input  logic [BW_WET-1:0]                       wet_rd_data,
    output logic                                    PE_mac_enable,
    output logic                                    PE_clear_acc,
    output logic                                    PE_weight_partial_sel,
    output logic [ACCU_NUM-1:0][BW_ACT-1:0]         PE_act_in,
    output logic [BW_WET-1:0]                       PE_wet_in,
    output logic [7:0]                              PE_res_shift_num,
    input  logic [BN_NUM-1:0][BW_ACT-1:0]           PE_result_out,
    output logic                                    oa_wr_en,
    output logic [$clog2(IA_H)-1:0]                 oa_wr_row,
    output logic [$clog2(OA_W)-1:0]                 oa_wr_col,
    output logic [BW_ACT-1:0]                       oa_wr_data
`ifdef SA_FEEDER_PERF_EN
    ,
    output logic [31:0]                             perf_cycles,
    output logic [15:0]                             perf_writes
`endif
);

    localparam int ROW_W = $clog2(IA_H);
    localparam int COL_W = $clog2(IA_W);
    localparam int OAC_W = $clog2(OA_W);
    localparam int N_W   = (BN_NUM > 1) ? $clog2(BN_NUM) : 1;

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(ACCU_NUM - 1);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(BN_NUM + ACCU_NUM - 1);
    localparam logic [CNT_W-1:0] I_LAST = CNT_W'(IA_W / ACCU_NUM - 1);
    localparam logic [CNT_W-1:0] J_LAST = CNT_W'(IA_H / BN_NUM - 1);
    localparam logic [CNT_W-1:0] M_LAST = CNT_W'(OA_W - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(BN_NUM - 1);

    state_t state, state_next;
    logic [CNT_W-1:0] m, j, i, k, l;

    logic [ACCU_NUM-1:0][ROW_W-1:0] skew_row;
    logic [ACCU_NUM-1:0][COL_W-1:0] skew_col;
    logic [ACCU_NUM-1:0]            skew_valid;

    logic [ACCU_NUM-1:0]            mask_q;
    logic                           partial_q;
    logic                           clear_q;
    logic [7:0]                     shift_q;
    logic [BN_NUM-1:0][BW_ACT-1:0]  res_q;

    sa_feed_skew #(
        .BN_NUM   (BN_NUM),
        .ACCU_NUM (ACCU_NUM),
        .ROW_W    (ROW_W),
        .COL_W    (COL_W)
    ) u_skew (
        .l     (l),
        .i     (i),
        .j     (j),
        .rows  (skew_row),
        .cols  (skew_col),
        .valid (skew_valid)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state: m outer, j middle, i inner loop; each (m,j) tile ends with drain/clear/capture/write
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD_W;
            LOAD_W:  if (k == K_LAST) state_next = FEED;
            FEED:    if (l == L_LAST) state_next = (i == I_LAST) ? DRAIN : LOAD_W;
            DRAIN:   if (k == D_LAST) state_next = CLEAR;
            CLEAR:   state_next = CAPTURE;
            CAPTURE: state_next = WRITE;
            WRITE:   if (k == N_LAST) state_next = (m == M_LAST && j == J_LAST) ? DONE : LOAD_W;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Loop counters; k is reused for weight-load step, drain count and write index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m <= '0; j <= '0; i <= '0; k <= '0; l <= '0;
        end else begin
            case (state)
                IDLE: begin
                    m <= '0; j <= '0; i <= '0; k <= '0; l <= '0;
                end
                LOAD_W: begin
                    if (k == K_LAST) begin
                        k <= '0;
                        l <= CNT_W'(1);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                FEED: begin
                    if (l == L_LAST) begin
                        l <= '0;
                        i <= (i == I_LAST) ? '0 : i + 1'b1;
                    end else begin
                        l <= l + 1'b1;
                    end
                end
                DRAIN: k <= (k == D_LAST) ? '0 : k + 1'b1;
                WRITE: begin
                    if (k == N_LAST) begin
                        k <= '0;
                        if (j == J_LAST) begin
                            j <= '0;
                            m <= m + 1'b1;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array-side controls lag the state by one cycle to line up with buffer read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q    <= '0;
            partial_q <= 1'b0;
            clear_q   <= 1'b0;
            shift_q   <= '0;
        end else begin
            mask_q    <= (state == FEED) ? skew_valid : '0;
            partial_q <= (state == LOAD_W);
            clear_q   <= (state == CLEAR);
            shift_q   <= res_shift_num;
        end
    end

    // Snapshot of the whole column result, taken while the accumulators still hold it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               res_q <= '0;
        else if (state == CAPTURE)  res_q <= PE_result_out;
    end

    // Activation lanes outside the skew window are forced to zero
    always_comb begin
        PE_act_in = '0;
        for (int idx = 0; idx < ACCU_NUM; idx++) begin
            if (mask_q[idx]) PE_act_in[idx] = act_rd_data[idx];
        end
    end

    assign busy                  = (state != IDLE);
    assign done                  = (state == DONE);
    assign PE_mac_enable         = busy;
    assign PE_clear_acc          = clear_q;
    assign PE_weight_partial_sel = partial_q;
    assign PE_wet_in             = partial_q ? wet_rd_data : '0;
    assign PE_res_shift_num      = shift_q;

    assign act_rd_row = (state == FEED) ? skew_row : '0;
    assign act_rd_col = (state == FEED) ? skew_col : '0;
    assign wet_rd_row = (state == LOAD_W) ? COL_W'(int'(i) * ACCU_NUM + ACCU_NUM - 1 - int'(k)) : '0;
    assign wet_rd_col = (state == LOAD_W) ? OAC_W'(m) : '0;

    assign oa_wr_en   = (state == WRITE);
    assign oa_wr_row  = oa_wr_en ? ROW_W'(int'(j) * BN_NUM + int'(k)) : '0;
    assign oa_wr_col  = oa_wr_en ? OAC_W'(m) : '0;
    assign oa_wr_data = oa_wr_en ? res_q[k[N_W-1:0]] : '0;

`ifdef SA_FEEDER_PERF_EN
    // Busy-cycle and write counters; cleared when a job is accepted, held after completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles <= '0;
            perf_writes <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= '0;
            perf_writes <= '0;
        end else begin
            if (busy)     perf_cycles <= perf_cycles + 1'b1;
            if (oa_wr_en) perf_writes <= perf_writes + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_feeder.sv
// Scoreboard bench for sa_feeder: buffer models, a behavioural PE column, golden matmul expectations.
module tb_sa_feeder;
    import sa_pkg::*;

    localparam int BN_NUM   = 4;
    localparam int ACCU_NUM = 2;
    localparam int IA_H     = 8;
    localparam int IA_W     = 8;
    localparam int OA_W     = 8;
    localparam int JOB_CYC  = 593;

    logic clk, reset_n, start, busy, done;
    logic [7:0] res_shift_num, PE_res_shift_num;
    logic [ACCU_NUM-1:0][2:0] act_rd_row, act_rd_col;
    logic [ACCU_NUM-1:0][7:0] act_rd_data, PE_act_in;
    logic [2:0] wet_rd_row, wet_rd_col, oa_wr_row, oa_wr_col;
    logic [7:0] wet_rd_data, PE_wet_in, oa_wr_data;
    logic PE_mac_enable, PE_clear_acc, PE_weight_partial_sel, oa_wr_en;
    logic [BN_NUM-1:0][7:0] PE_result_out;
`ifdef SA_FEEDER_PERF_EN
    logic [31:0] perf_cycles;
    logic [15:0] perf_writes;
`endif

    typedef struct {
        logic [2:0] row;
        logic [2:0] col;
        logic [7:0] data;
    } wr_t;

    wr_t  expQ[$];
    wr_t  e;
    act_t actMem [IA_H][IA_W];
    wet_t wetMem [IA_W][OA_W];
    int   acc    [BN_NUM];
    int   wreg   [ACCU_NUM];
    int   feedCnt;
    int   checks, errors, writeCount;

    sa_feeder dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .res_shift_num(res_shift_num),
        .act_rd_row(act_rd_row), .act_rd_col(act_rd_col), .act_rd_data(act_rd_data),
        .wet_rd_row(wet_rd_row), .wet_rd_col(wet_rd_col), .wet_rd_data(wet_rd_data),
        .PE_mac_enable(PE_mac_enable), .PE_clear_acc(PE_clear_acc),
        .PE_weight_partial_sel(PE_weight_partial_sel),
        .PE_act_in(PE_act_in), .PE_wet_in(PE_wet_in), .PE_res_shift_num(PE_res_shift_num),
        .PE_result_out(PE_result_out),
        .oa_wr_en(oa_wr_en), .oa_wr_row(oa_wr_row), .oa_wr_col(oa_wr_col), .oa_wr_data(oa_wr_data)
`ifdef SA_FEEDER_PERF_EN
        , .perf_cycles(perf_cycles), .perf_writes(perf_writes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer SRAM models with one-cycle read latency
    always @(posedge clk) begin
        for (int idx = 0; idx < ACCU_NUM; idx++)
            act_rd_data[idx] <= actMem[act_rd_row[idx]][act_rd_col[idx]];
        wet_rd_data <= wetMem[wet_rd_row][wet_rd_col];
    end

    // PE column model: weight chain shifts in at lane 0, skewed feeds accumulate per row
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < BN_NUM; b++) acc[b] <= 0;
            for (int q = 0; q < ACCU_NUM; q++) wreg[q] <= 0;
            feedCnt <= 0;
        end else begin
            if (PE_clear_acc) begin
                for (int b = 0; b < BN_NUM; b++) acc[b] <= 0;
            end else if (PE_mac_enable && !PE_weight_partial_sel) begin
                for (int idx = 0; idx < ACCU_NUM; idx++)
                    if (feedCnt - idx >= 0 && feedCnt - idx < BN_NUM)
                        acc[feedCnt - idx] <= acc[feedCnt - idx] + int'($signed(PE_act_in[idx])) * wreg[idx];
            end
            if (PE_weight_partial_sel) begin
                for (int q = ACCU_NUM - 1; q > 0; q--) wreg[q] <= wreg[q-1];
                wreg[0] <= int'($signed(PE_wet_in));
                feedCnt <= 0;
            end else begin
                feedCnt <= feedCnt + 1;
            end
        end
    end

    // Array result bus: arithmetic shift then truncate to result width
    always_comb begin
        PE_result_out = '0;
        for (int b = 0; b < BN_NUM; b++) PE_result_out[b] = 8'(acc[b] >>> PE_res_shift_num);
    end

    // Compare helper shared by the stimulus and the monitor
    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every output-buffer write is matched against the scoreboard queue
    always @(negedge clk) begin
        if (oa_wr_en === 1'b1) begin
            writeCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL oa_write_unexpected: got row %0d col %0d data %0h, none expected",
                         oa_wr_row, oa_wr_col, oa_wr_data);
            end else begin
                e = expQ.pop_front();
                checkOutput("oa_write", 128'({oa_wr_row, oa_wr_col, oa_wr_data}),
                            128'({e.row, e.col, e.data}));
            end
        end
    end

    function automatic logic [127:0] outVec();
        return 128'({busy, done, oa_wr_en, oa_wr_row, oa_wr_col, oa_wr_data, act_rd_row, act_rd_col,
                     wet_rd_row, wet_rd_col, PE_mac_enable, PE_clear_acc, PE_weight_partial_sel,
                     PE_act_in, PE_wet_in, PE_res_shift_num});
    endfunction

    function automatic logic [7:0] golden(input int r, input int c, input logic [7:0] sh);
        int s;
        s = 0;
        for (int q = 0; q < IA_W; q++) s += int'(actMem[r][q]) * int'(wetMem[q][c]);
        return 8'(s >>> sh);
    endfunction

    task automatic fillMem(input int mode);
        for (int r = 0; r < IA_H; r++)
            for (int c = 0; c < IA_W; c++) begin
                case (mode)
                    0:       actMem[r][c] = act_t'(3*r - 2*c + 1);
                    2:       actMem[r][c] = act_t'(-1);
                    default: actMem[r][c] = act_t'(r*8 + c);
                endcase
            end
        for (int r = 0; r < IA_W; r++)
            for (int c = 0; c < OA_W; c++) begin
                case (mode)
                    0:       wetMem[r][c] = wet_t'(((r + 2*c) % 5) - 2);
                    2:       wetMem[r][c] = wet_t'(-128);
                    default: wetMem[r][c] = (r == c) ? wet_t'(64) : wet_t'(0);
                endcase
            end
    endtask

    // One job: queue expected writes, pulse start, follow it to completion with directed probes
    task automatic applyStimulus(input int mode, input logic [7:0] sh);
        int c, doneSeen, wrBefore;
        wr_t w;
        wrBefore = writeCount;
        for (int m = 0; m < OA_W; m++)
            for (int j = 0; j < IA_H / BN_NUM; j++)
                for (int n = 0; n < BN_NUM; n++) begin
                    w.row  = 3'(j*BN_NUM + n);
                    w.col  = 3'(m);
                    w.data = golden(j*BN_NUM + n, m, sh);
                    expQ.push_back(w);
                end
        res_shift_num = sh;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        c = 0;
        doneSeen = 0;
        while (busy === 1'b1 && c < 2000) begin
            c++;
            if (done === 1'b1) doneSeen++;
            if (mode == 0) begin
                case (c)
                    1: checkOutput("mac_enable_c1", 128'(PE_mac_enable), 128'(1));
                    2: checkOutput("wet_first_W10", 128'({PE_weight_partial_sel, PE_wet_in}), 128'({1'b1, 8'hFF}));
                    3: checkOutput("wet_second_W00", 128'({PE_weight_partial_sel, PE_wet_in}), 128'({1'b1, 8'hFE}));
                    4: checkOutput("feed_l1_lanes", 128'({PE_weight_partial_sel, PE_act_in}), 128'({1'b0, 8'd0, 8'd1}));
                    8: checkOutput("feed_l5_lanes", 128'(PE_act_in), 128'({8'd8, 8'd0}));
                    default: ;
                endcase
            end
            if (mode == 1 && c == 200) start = 1'b1;
            if (mode == 1 && c == 201) start = 1'b0;
            if (mode == 3 && c == 100) begin
                reset_n = 1'b0;
                #1;
                checkOutput("abort_outputs_zero", outVec(), 128'(0));
                break;
            end
            @(negedge clk);
        end
        if (mode == 3) begin
            repeat (2) @(negedge clk);
            checkOutput("abort_held_zero", outVec(), 128'(0));
            checkOutput("abort_no_done", 128'(doneSeen), 128'(0));
            reset_n = 1'b1;
            expQ.delete();
            @(negedge clk);
        end else begin
            checkOutput("busy_cycles", 128'(c), 128'(JOB_CYC));
            checkOutput("done_pulses", 128'(doneSeen), 128'(1));
            checkOutput("write_count", 128'(writeCount - wrBefore), 128'(64));
            checkOutput("scoreboard_empty", 128'(expQ.size()), 128'(0));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        writeCount = 0;
        reset_n = 1'b0;
        start = 1'b0;
        res_shift_num = 8'd5;
        fillMem(1);
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", outVec(), 128'(0));
`ifdef SA_FEEDER_PERF_EN
        checkOutput("reset_perf", 128'({perf_cycles, perf_writes}), 128'(0));
`endif
        reset_n = 1'b1;
        @(negedge clk);
        $display("[TB] job: mixed-sign operands with single-tile probes");
        fillMem(0); applyStimulus(0, 8'd2);
        $display("[TB] job: identity weights, ramp activations, extra start mid-run");
        fillMem(1); applyStimulus(1, 8'd6);
        $display("[TB] job: all-negative operands");
        fillMem(2); applyStimulus(2, 8'd8);
        $display("[TB] job: reset abort at cycle 100");
        fillMem(1); applyStimulus(3, 8'd6);
        $display("[TB] job: fresh start after abort");
        applyStimulus(4, 8'd6);
`ifdef SA_FEEDER_PERF_EN
        checkOutput("perf_cycles", 128'(perf_cycles), 128'(JOB_CYC));
        checkOutput("perf_writes", 128'(perf_writes), 128'(64));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_feeder.md
Name: sa_feeder

Overview:
- Hardware sequencer that drives one systolic-array PE column (BN_NUM MAC rows × ACCU_NUM accumulate lanes) from on-chip activation and weight buffers.
- Captures the array results into an output-activation buffer.
- Acts as the initiator for the array's load-weight / skewed-feed / clear / read-result protocol; replaces host-side stimulus sequencing.
- Sits between the buffer SRAMs and the array; one start/done handshake to the top controller.

Parameters:
- BN_NUM, 4, number of MAC rows (outputs per column).
- ACCU_NUM, 2, accumulate lanes / activation inputs.
- BW_ACT, 8, activation and result width.
- BW_WET, 8, weight width.
- IA_H, 8, input activation rows; must be a multiple of BN_NUM.
- IA_W, 8, input activation cols = weight rows; must be a multiple of ACCU_NUM.
- OA_W, 8, output cols = weight cols.
- DRAIN_CYC, 3, idle cycles between last feed and clear.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from cycle after start accepted until done.
- done  out  1  one-cycle pulse at completion.
- res_shift_num  in  8  passed through to PE_res_shift_num.
- act_rd_row  out  ACCU_NUM×clog2(IA_H)  per-lane activation row address.
- act_rd_col  out  ACCU_NUM×clog2(IA_W)  per-lane activation col address.
- act_rd_data  in  ACCU_NUM×BW_ACT  signed; valid 1 cycle after address.
- wet_rd_row  out  clog2(IA_W)  weight row address.
- wet_rd_col  out  clog2(OA_W)  weight col address.
- wet_rd_data  in  BW_WET  signed; latency 1.
- PE_mac_enable, PE_clear_acc, PE_weight_partial_sel  out  1 each  array control.
- PE_act_in  out  ACCU_NUM×BW_ACT  signed activations to array.
- PE_wet_in  out  BW_WET  signed weight to array.
- PE_res_shift_num  out  8  result shift.
- PE_result_out  in  BN_NUM×BW_ACT  signed array results.
- oa_wr_en  out  1  output buffer write strobe.
- oa_wr_row  out  clog2(IA_H)  write row.
- oa_wr_col  out  clog2(OA_W)  write col.
- oa_wr_data  out  BW_ACT  signed write data.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters m/j/i/k/l cleared. Reset asserted mid-operation aborts immediately; no done pulse.
- States: IDLE, LOAD_W, FEED, DRAIN, CLEAR, CAPTURE, WRITE, DONE. Loops are m (0..OA_W-1) outer, j (0..IA_H/BN_NUM-1), i (0..IA_W/ACCU_NUM-1) inner.
- LOAD_W: ACCU_NUM cycles, k = 0..ACCU_NUM-1.
  - Address W[i*ACCU_NUM+ACCU_NUM-1-k][m].
  - partial_sel = 1.
- FEED: BN_NUM+ACCU_NUM-1 cycles, l = 1..BN_NUM+ACCU_NUM-1, partial_sel = 0.
  - Lane idx is valid iff 0 ≤ l-1-idx < BN_NUM.
  - Address for a valid lane: A[j*BN_NUM+l-1-idx][i*ACCU_NUM+idx].
  - Invalid lanes are forced to 0 via a lane mask.
  - Next i → LOAD_W; last i → DRAIN.
- DRAIN: DRAIN_CYC cycles, activations 0.
- CLEAR: 1 cycle, PE_clear_acc = 1.
- CAPTURE: 1 cycle; latch all PE_result_out into a BN_NUM-entry result register.
- WRITE: BN_NUM cycles, n = 0..BN_NUM-1.
  - oa_wr_en = 1, row = j*BN_NUM+n, col = m.
  - Next (m,j) → LOAD_W; last → DONE.
- DONE: done = 1 for one cycle, then → IDLE.
- Array-side signals: PE_*, lane mask and partial_sel are registered one cycle behind the state, aligning with read latency.
  - PE_wet_in and PE_act_in update on the same cycle the array sees the matching partial_sel.
  - oa_* outputs are not delayed.
- PE_mac_enable = busy.
- Per (m,j): (IA_W/ACCU_NUM)·(ACCU_NUM+BN_NUM+ACCU_NUM-1) + DRAIN_CYC + 1 + 1 + BN_NUM cycles. Defaults: 28+3+1+1+4 = 37.
- Total busy = OA_W·(IA_H/BN_NUM)·37 + 1 (DONE) = 593 with defaults.
- start while busy is ignored. start in the same cycle as done completing is ignored; start is sampled only in IDLE.

Optional Feature:
- SA_FEEDER_PERF_EN defined: adds outputs perf_cycles (32) and perf_writes (16).
  - Both clear on start accept.
  - perf_cycles increments every busy cycle.
  - perf_writes increments per oa_wr_en.
  - Both hold after done.
- SA_FEEDER_PERF_EN undefined: ports and logic are absent.

Decomposition:
- Package sa_pkg: state enum, default BN_NUM/ACCU_NUM/BW_* localparams, signed act/wet typedefs.
- Sub-module sa_feed_skew: computes per-lane addresses and valid mask from (l, i, j). Combinational, reusable by a future row-stationary feeder.

Test Plan:
- Identity weights (W[r][c] = r==c ? 64 : 0), shift 6, A = ramp 0..63 → oa buffer equals A, matched against a golden model; done after exactly 593 busy cycles.
- Single-tile check: first FEED cycle gives lane0 = A[0][0], lane1 = 0. At l = 5: lane0 = 0, lane1 = A[3][1]. PE_wet_in sequence is W[1][0] then W[0][0].
- All-negative operands (A = -1, W = -128, shift 8) → every output matches the reference with sign-correct values.
- start pulsed again mid-run → ignored; exactly 64 oa_wr_en total and one done.
- reset_n dropped at cycle 100 → all outputs 0 asynchronously. A fresh start then completes normally in 593 cycles.
- With SA_FEEDER_PERF_EN: perf_cycles = 593, perf_writes = 64 after done.
